layernorm_stats_frontend: RTL

- Upstream producer for the LayerNorm post-processing stage.
- Accepts one 16-element Q5.10 token vector as a serial element stream.
- Computes the mean μ, the difference vector (xi − μ) and 1/σ with a bit-exact integer square root and divider.
- Presents all results as one wide, single-cycle valid pulse matching the post-processing input interface (valid, inv_sigma, mean, diff_vector_0..15).

---
 rtl/layernorm_stats_frontend.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/layernorm_stats_frontend.sv
// rtl/layernorm_stats_frontend.sv - LayerNorm front end: collects a 16-element Q5.10 vector, emits mean, diffs and 1/sigma.
module layernorm_stats_frontend #(
  parameter int EPS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic        valid_out,
  output logic [15:0] inv_sigma_out,
  output logic [15:0] mean_out,
  output logic [15:0] diff_vector_out_0,
  output logic [15:0] diff_vector_out_1,
  output logic [15:0] diff_vector_out_2,
  output logic [15:0] diff_vector_out_3,
  output logic [15:0] diff_vector_out_4,
  output logic [15:0] diff_vector_out_5,
  output logic [15:0] diff_vector_out_6,
  output logic [15:0] diff_vector_out_7,
  output logic [15:0] diff_vector_out_8,
  output logic [15:0] diff_vector_out_9,
  output logic [15:0] diff_vector_out_10,
  output logic [15:0] diff_vector_out_11,
  output logic [15:0] diff_vector_out_12,
  output logic [15:0] diff_vector_out_13,
  output logic [15:0] diff_vector_out_14,
  output logic [15:0] diff_vector_out_15
);

  typedef enum logic [2:0] {S_COLLECT, S_MEAN, S_DIFF, S_VAR, S_SQRT, S_DIV, S_EMIT} state_t;

  state_t       r_state, w_next;
  logic [4:0]   r_cnt;
  logic [15:0]  r_x    [16];
  logic [15:0]  r_diff [16];
  logic [15:0]  r_dout [16];
  logic [19:0]  r_sum;
  logic [35:0]  r_sumsq;
  logic [15:0]  r_mean, r_mean_out, r_inv_out;
  logic         r_valid;
  logic [25:0]  r_rad;
  logic [15:0]  r_rem;
  logic [12:0]  r_root;
  logic [20:0]  r_dvd, r_quo;
  logic [13:0]  r_drem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: if (in_valid && r_cnt == 5'd15) w_next = S_MEAN;
      S_MEAN:    w_next = S_DIFF;
      S_DIFF:    if (r_cnt == 5'd15) w_next = S_VAR;
      S_VAR:     w_next = S_SQRT;
      S_SQRT:    if (r_cnt == 5'd12) w_next = S_DIV;
      S_DIV:     if (r_cnt == 5'd20) w_next = S_EMIT;
      S_EMIT:    w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  logic signed [16:0] w_d17;
  logic [15:0]        w_dsat;
  logic signed [31:0] w_sq;
  logic [35:0]        w_vshift;
  logic [15:0]        w_vsat, w_var;
  logic [16:0]        w_veps;
  logic [15:0]        w_srem, w_trial;
  logic [13:0]        w_drem;
  logic [15:0]        w_inv;

  always_comb begin
    w_d17  = $signed({r_x[r_cnt[3:0]][15], r_x[r_cnt[3:0]]}) - $signed({r_mean[15], r_mean});
    // Overflow of the 17-bit difference shows as disagreeing top two bits
    w_dsat = (w_d17[16] != w_d17[15]) ? (w_d17[16] ? 16'h8000 : 16'h7FFF) : w_d17[15:0];
    w_sq   = $signed(w_dsat) * $signed(w_dsat);

    w_vshift = r_sumsq >> 14;
    w_vsat   = (|w_vshift[35:16]) ? 16'hFFFF : w_vshift[15:0];
    w_veps   = {1'b0, w_vsat} + 17'(EPS);
    w_var    = w_veps[16] ? 16'hFFFF : w_veps[15:0];

    w_srem  = {r_rem[13:0], r_rad[25:24]};
    w_trial = {1'b0, r_root, 2'b01};
    w_drem  = {r_drem[12:0], r_dvd[20]};

    w_inv = (r_root == 13'd0 || |r_quo[20:15]) ? 16'h7FFF : r_quo[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_sum      <= '0;
      r_sumsq    <= '0;
      r_mean     <= '0;
      r_mean_out <= '0;
      r_inv_out  <= '0;
      r_valid    <= 1'b0;
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_dvd      <= '0;
      r_quo      <= '0;
      r_drem     <= '0;
      for (int i = 0; i < 16; i++) begin
        r_x[i]    <= '0;
        r_diff[i] <= '0;
        r_dout[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_COLLECT) begin
        if (in_valid) begin
          r_x[r_cnt[3:0]] <= in_data;
          r_sum           <= r_sum + {{4{in_data[15]}}, in_data};
          r_cnt           <= (r_cnt == 5'd15) ? 5'd0 : r_cnt + 5'd1;
        end
      end else begin
        r_cnt <= (w_next != r_state) ? 5'd0 : r_cnt + 5'd1;
      end

      case (r_state)
        S_MEAN: begin
          r_mean  <= r_sum[19:4];
          r_sum   <= '0;
          r_sumsq <= '0;
        end
        S_DIFF: begin
          r_diff[r_cnt[3:0]] <= w_dsat;
          r_sumsq            <= r_sumsq + {4'b0, w_sq};
        end
        S_VAR: begin
          r_rad  <= {w_var, 10'b0};
          r_rem  <= '0;
          r_root <= '0;
          r_dvd  <= 21'h100000;
          r_drem <= '0;
          r_quo  <= '0;
        end
        S_SQRT: begin
          r_rad <= r_rad << 2;
          if (w_srem >= w_trial) begin
            r_rem  <= w_srem - w_trial;
            r_root <= {r_root[11:0], 1'b1};
          end else begin
            r_rem  <= w_srem;
            r_root <= {r_root[11:0], 1'b0};
          end
        end
        S_DIV: begin
          r_dvd <= r_dvd << 1;
          if (w_drem >= {1'b0, r_root}) begin
            r_drem <= w_drem - {1'b0, r_root};
            r_quo  <= {r_quo[19:0], 1'b1};
          end else begin
            r_drem <= w_drem;
            r_quo  <= {r_quo[19:0], 1'b0};
          end
        end
        S_EMIT: begin
          r_mean_out <= r_mean;
          r_inv_out  <= w_inv;
          r_valid    <= 1'b1;
          for (int i = 0; i < 16; i++) r_dout[i] <= r_diff[i];
        end
        default: ;
      endcase
    end
  end

  assign in_ready           = (r_state == S_COLLECT);
  assign busy               = (r_state != S_COLLECT);
  assign valid_out          = r_valid;
  assign inv_sigma_out      = r_inv_out;
  assign mean_out           = r_mean_out;
  assign diff_vector_out_0  = r_dout[0];
  assign diff_vector_out_1  = r_dout[1];
  assign diff_vector_out_2  = r_dout[2];
  assign diff_vector_out_3  = r_dout[3];
  assign diff_vector_out_4  = r_dout[4];
  assign diff_vector_out_5  = r_dout[5];
  assign diff_vector_out_6  = r_dout[6];
  assign diff_vector_out_7  = r_dout[7];
  assign diff_vector_out_8  = r_dout[8];
  assign diff_vector_out_9  = r_dout[9];
  assign diff_vector_out_10 = r_dout[10];
  assign diff_vector_out_11 = r_dout[11];
  assign diff_vector_out_12 = r_dout[12];
  assign diff_vector_out_13 = r_dout[13];
  assign diff_vector_out_14 = r_dout[14];
  assign diff_vector_out_15 = r_dout[15];

endmodule
